// File: rtl/sa_pkg.sv
// Shared sa link constants, used by both the receive and transmit queues.
package sa_pkg;
  localparam int unsigned SA_PKT_W   = 57;
  localparam int unsigned SA_Q_DEPTH = 8;
endpackage

// File: rtl/sa_rx_ptr_ctrl.sv
// Pointer, occupancy and ready/valid flag control for the sa receive queue.
module sa_rx_ptr_ctrl
  import sa_pkg::*;
#(
  parameter int unsigned DEPTH = SA_Q_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_vld,
  input  logic                       out_rdy,
  output logic                       in_rdy,
  output logic                       out_vld,
  output logic                       push_c,
  output logic [$clog2(DEPTH)-1:0]   wp,
  output logic [$clog2(DEPTH)-1:0]   rp,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic [$clog2(DEPTH):0]     cnt_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic          pop_c;
  logic [AW-1:0] wp_nxt;
  logic [AW-1:0] rp_nxt;

  assign push_c = in_vld & in_rdy;
  assign pop_c  = out_vld & out_rdy;

  // Next pointer/occupancy; flush discards any same-cycle push or pop.
  always_comb begin
    wp_nxt    = wp;
    rp_nxt    = rp;
    cnt_nxt_c = cnt;
    if (flush) begin
      wp_nxt    = '0;
      rp_nxt    = '0;
      cnt_nxt_c = '0;
    end else begin
      if (push_c) wp_nxt = wp + AW'(1);
      if (pop_c)  rp_nxt = rp + AW'(1);
      case ({push_c, pop_c})
        2'b10:   cnt_nxt_c = cnt + CW'(1);
        2'b01:   cnt_nxt_c = cnt - CW'(1);
        default: cnt_nxt_c = cnt;
      endcase
    end
  end

  // Flags are registered from the next occupancy so they track cnt exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
    end else begin
      wp      <= wp_nxt;
      rp      <= rp_nxt;
      cnt     <= cnt_nxt_c;
      in_rdy  <= (cnt_nxt_c != CW'(DEPTH));
      out_vld <= (cnt_nxt_c != CW'(0));
    end
  end

endmodule

// File: rtl/sa_rx_queue.sv
// In-order receive packet queue for the sa link.
// Optional occupancy high-water mark enabled by SA_RX_QUEUE_HWM_EN.
module sa_rx_queue
  import sa_pkg::*;
#(
  parameter int unsigned PKT_W = SA_PKT_W,
  parameter int unsigned DEPTH = SA_Q_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [PKT_W-1:0]         in_dat,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [PKT_W-1:0]         out_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   hwm
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic             push_c;
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [PKT_W-1:0] mem [DEPTH];

  sa_rx_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_vld    (in_vld),
    .out_rdy   (out_rdy),
    .in_rdy    (in_rdy),
    .out_vld   (out_vld),
    .push_c    (push_c),
    .wp        (wp),
    .rp        (rp),
    .cnt       (cnt),
    .cnt_nxt_c (cnt_nxt)
  );

  // Storage is not reset; contents are only observed behind out_vld.
  always_ff @(posedge clk) begin
    if (push_c) mem[wp] <= in_dat;
  end

  assign out_dat = mem[rp];
  assign count   = cnt;

`ifdef SA_RX_QUEUE_HWM_EN
  logic [CW-1:0] hwm_q;

  // Tracks peak occupancy; bounded by DEPTH since cnt never exceeds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  hwm_q <= '0;
    else if (cnt_nxt > hwm_q) hwm_q <= cnt_nxt;
  end

  assign hwm = hwm_q;
`else
  logic unused_cnt_nxt;
  assign unused_cnt_nxt = ^cnt_nxt;
  assign hwm            = '0;
`endif

endmodule
